// File: rtl/pwm_cfg_ctrl.sv
// rtl/pwm_cfg_ctrl.sv - SPI frame decoder driving PWM enable and duty configuration (optional PWM_CFG_RAMP_EN duty ramp)
module pwm_cfg_ctrl #(
    parameter logic [7:0] DUTY_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    input  logic [15:0] frame_data,
    input  logic        period_start,
    output logic [7:0]  en_reg_out_7_0,
    output logic [7:0]  en_reg_out_15_8,
    output logic [7:0]  en_reg_pwm_7_0,
    output logic [7:0]  en_reg_pwm_15_8,
    output logic [7:0]  pwm_duty_cycle,
    output logic        duty_pending,
    output logic [3:0]  err_cnt
);

`ifdef PWM_CFG_RAMP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RAMP  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1
    } state_t;
`endif

    localparam logic [6:0] ADDR_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY   = 7'h04;

    // Frame fields
    logic       wr_frame;
    logic [6:0] frame_addr;
    logic [7:0] frame_byte;
    logic       duty_wr;
    logic       bad_wr;

    // Enable registers
    logic [7:0] out_lo_q, out_lo_d;
    logic [7:0] out_hi_q, out_hi_d;
    logic [7:0] pwm_lo_q, pwm_lo_d;
    logic [7:0] pwm_hi_q, pwm_hi_d;

    // Error counter
    logic [3:0] err_cnt_q, err_cnt_d;

    // Duty path
    state_t     state_q, state_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] target_q, target_d;
    logic [7:0] active_q, active_d;

`ifdef PWM_CFG_RAMP_EN
    logic [7:0] step_val;
`endif

    assign wr_frame   = frame_valid & frame_data[15];
    assign frame_addr = frame_data[14:8];
    assign frame_byte = frame_data[7:0];
    assign duty_wr    = wr_frame & (frame_addr == ADDR_DUTY);
    assign bad_wr     = wr_frame & (frame_addr > ADDR_DUTY);

    // Enable register and error counter next-state: writes land on the next edge
    always_comb begin
        out_lo_d  = out_lo_q;
        out_hi_d  = out_hi_q;
        pwm_lo_d  = pwm_lo_q;
        pwm_hi_d  = pwm_hi_q;
        err_cnt_d = err_cnt_q;
        if (wr_frame) begin
            case (frame_addr)
                ADDR_OUT_LO: out_lo_d = frame_byte;
                ADDR_OUT_HI: out_hi_d = frame_byte;
                ADDR_PWM_LO: pwm_lo_d = frame_byte;
                ADDR_PWM_HI: pwm_hi_d = frame_byte;
                default:     out_lo_d = out_lo_q;
            endcase
        end
        if (bad_wr && (err_cnt_q != 4'hF)) begin
            err_cnt_d = err_cnt_q + 4'd1;
        end
    end

    // Enable registers and error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lo_q  <= 8'h00;
            out_hi_q  <= 8'h00;
            pwm_lo_q  <= 8'h00;
            pwm_hi_q  <= 8'h00;
            err_cnt_q <= 4'h0;
        end else begin
            out_lo_q  <= out_lo_d;
            out_hi_q  <= out_hi_d;
            pwm_lo_q  <= pwm_lo_d;
            pwm_hi_q  <= pwm_hi_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Duty FSM next-state: a duty write always wins over a coincident period_start,
    // so a commit only ever happens on a period_start after the accepting cycle
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        target_d = target_q;
        active_d = active_q;
`ifdef PWM_CFG_RAMP_EN
        step_val = active_q;
`endif
        if (duty_wr) begin
            shadow_d = frame_byte;
            state_d  = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (period_start) begin
                        target_d = shadow_q;
`ifdef PWM_CFG_RAMP_EN
                        state_d  = (active_q == shadow_q) ? ST_IDLE : ST_RAMP;
`else
                        active_d = shadow_q;
                        state_d  = ST_IDLE;
`endif
                    end
                end
`ifdef PWM_CFG_RAMP_EN
                ST_RAMP: begin
                    if (period_start) begin
                        // Guards on the rails keep the step from wrapping
                        if ((active_q < target_q) && (active_q != 8'hFF)) begin
                            step_val = active_q + 8'd1;
                        end else if ((active_q > target_q) && (active_q != 8'h00)) begin
                            step_val = active_q - 8'd1;
                        end else begin
                            step_val = active_q;
                        end
                        active_d = step_val;
                        if (step_val == target_q) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
`endif
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Duty FSM state and duty registers; reset discards any armed commit or ramp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= DUTY_RESET;
            target_q <= DUTY_RESET;
            active_q <= DUTY_RESET;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            target_q <= target_d;
            active_q <= active_d;
        end
    end

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = active_q;
    assign duty_pending    = (state_q != ST_IDLE);
    assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// tb/tb_pwm_cfg_ctrl.sv - self-checking bench for pwm_cfg_ctrl
module tb_pwm_cfg_ctrl;

    localparam logic [7:0] DR = 8'h00;

    logic        clk;
    logic        rst_n;
    logic        frame_valid;
    logic [15:0] frame_data;
    logic        period_start;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic        duty_pending;
    logic [3:0]  err_cnt;

    int checks;
    int errors;

    // Model state
    logic [7:0] m_en [4];
    logic [3:0] m_err;
    logic [7:0] m_shadow;
    logic [7:0] m_target;
    logic [7:0] m_active;
    logic       m_armed;
    bit         ramp_build;

    pwm_cfg_ctrl #(.DUTY_RESET(DR)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_valid     (frame_valid),
        .frame_data      (frame_data),
        .period_start    (period_start),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .duty_pending    (duty_pending),
        .err_cnt         (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_en[i] = 8'h00;
        m_err    = 4'h0;
        m_shadow = DR;
        m_target = DR;
        m_active = DR;
        m_armed  = 1'b0;
    endtask

    // One clock edge of the register-level behaviour: enable writes, error count,
    // and the shadow/target/active duty chain with deferred commit
    task automatic model_update(input logic fv, input logic [15:0] fd, input logic ps);
        logic       wr;
        logic [6:0] a;
        wr = fv && fd[15];
        a  = fd[14:8];
        if (wr && a < 7'd4) m_en[a[1:0]] = fd[7:0];
        if (wr && a > 7'd4 && m_err < 4'd15) m_err = m_err + 4'd1;
        if (wr && a == 7'd4) begin
            m_shadow = fd[7:0];
            m_armed  = 1'b1;
        end else if (m_armed && ps) begin
            m_target = m_shadow;
            m_armed  = 1'b0;
            if (!ramp_build) m_active = m_shadow;
        end else if (ramp_build && ps && m_active != m_target) begin
            if (m_target > m_active) m_active = m_active + 8'd1;
            else                     m_active = m_active - 8'd1;
        end
    endtask

    // Drive one cycle of inputs from a negedge, model the posedge, return at the next negedge
    task automatic step(input logic fv, input logic [15:0] fd, input logic ps);
        frame_valid  = fv;
        frame_data   = fd;
        period_start = ps;
        @(posedge clk);
        if (rst_n) model_update(fv, fd, ps);
        @(negedge clk);
        frame_valid  = 1'b0;
        frame_data   = 16'h0000;
        period_start = 1'b0;
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("en_out_lo", en_reg_out_7_0,  m_en[0]);
            chk("en_out_hi", en_reg_out_15_8, m_en[1]);
            chk("en_pwm_lo", en_reg_pwm_7_0,  m_en[2]);
            chk("en_pwm_hi", en_reg_pwm_15_8, m_en[3]);
            chk("duty",      pwm_duty_cycle,  m_active);
            chk("pending",   {7'd0, duty_pending}, {7'd0, (m_armed || (m_active != m_target))});
            chk("err_cnt",   {4'd0, err_cnt}, {4'd0, m_err});
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_lo"},  en_reg_out_7_0, 8'h00);
        chk({tag, "_out_hi"},  en_reg_out_15_8, 8'h00);
        chk({tag, "_pwm_lo"},  en_reg_pwm_7_0, 8'h00);
        chk({tag, "_pwm_hi"},  en_reg_pwm_15_8, 8'h00);
        chk({tag, "_duty"},    pwm_duty_cycle, DR);
        chk({tag, "_pending"}, {7'd0, duty_pending}, 8'h00);
        chk({tag, "_err"},     {4'd0, err_cnt}, 8'h00);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_vals("async_rst");
        // Frames with unknown content while held in reset must be ignored
        frame_valid = 1'b1;
        frame_data  = 16'hxxxx;
        @(negedge clk);
        @(negedge clk);
        frame_valid = 1'b0;
        frame_data  = 16'h0000;
        rst_n = 1'b1;
        step(0, 16'h0000, 0);
        chk_reset_vals("post_rst");
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef PWM_CFG_RAMP_EN
        ramp_build = 1'b1;
`else
        ramp_build = 1'b0;
`endif
        model_reset();
        rst_n        = 1'b0;
        frame_valid  = 1'b0;
        frame_data   = 16'h0000;
        period_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step(0, 16'h0000, 0);
        chk_reset_vals("reset");

        // Enable writes visible one cycle after the strobe
        step(1, 16'h80A5, 0); chk("wr_out_lo", en_reg_out_7_0,  8'hA5);
        step(1, 16'h813C, 0); chk("wr_out_hi", en_reg_out_15_8, 8'h3C);
        step(1, 16'h82FF, 0); chk("wr_pwm_lo", en_reg_pwm_7_0,  8'hFF);
        step(1, 16'h8301, 0); chk("wr_pwm_hi", en_reg_pwm_15_8, 8'h01);

        // Deferred duty write
        step(1, 16'h8480, 0);
        chk("arm_pending", {7'd0, duty_pending}, 8'h01);
        chk("arm_duty_hold", pwm_duty_cycle, DR);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        chk("arm_duty_hold2", pwm_duty_cycle, DR);
        step(0, 16'h0000, 1);
`ifndef PWM_CFG_RAMP_EN
        chk("commit_80", pwm_duty_cycle, 8'h80);
        chk("commit_idle", {7'd0, duty_pending}, 8'h00);
`endif

        // Coincident frame and period_start: commit waits a period
        step(1, 16'h8440, 1);
        chk("coinc_pending", {7'd0, duty_pending}, 8'h01);
`ifndef PWM_CFG_RAMP_EN
        chk("coinc_hold", pwm_duty_cycle, 8'h80);
`endif
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 1);
`ifndef PWM_CFG_RAMP_EN
        chk("coinc_commit", pwm_duty_cycle, 8'h40);
`endif

        // Last write wins; reads are ignored
        step(1, 16'h8410, 0);
        step(1, 16'h8420, 0);
        step(0, 16'h0000, 1);
`ifndef PWM_CFG_RAMP_EN
        chk("lww_20", pwm_duty_cycle, 8'h20);
`endif
        step(1, 16'h0455, 0);
        step(1, 16'h0077, 0);
        chk("read_no_en", en_reg_out_7_0, 8'hA5);
`ifndef PWM_CFG_RAMP_EN
        chk("read_no_duty", pwm_duty_cycle, 8'h20);
        chk("read_no_pend", {7'd0, duty_pending}, 8'h00);
`endif

        // Invalid address: saturating error count, nothing else moves
        for (int i = 0; i < 17; i++) begin
            step(1, 16'h9011, 0);
            if (i == 0) chk("err_first", {4'd0, err_cnt}, 8'h01);
        end
        step(1, 16'hFF33, 0);
        chk("err_sat", {4'd0, err_cnt}, 8'h0F);
        chk("err_en_lo", en_reg_out_7_0, 8'hA5);
        chk("err_en_hi", en_reg_pwm_15_8, 8'h01);
`ifndef PWM_CFG_RAMP_EN
        chk("err_duty", pwm_duty_cycle, 8'h20);

        // Reset with a commit armed discards it
        step(1, 16'h8477, 0);
        chk("pre_rst_pend", {7'd0, duty_pending}, 8'h01);
        async_reset();
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 0);
        chk("rst_discard", pwm_duty_cycle, DR);
`else
        // Settle active at 02
        begin
            bit settled;
            settled = 1'b0;
            step(1, 16'h8402, 0);
            for (int i = 0; i < 400; i++) begin
                if (!duty_pending) begin
                    settled = 1'b1;
                    break;
                end
                step(0, 16'h0000, 1);
            end
            if (!settled) begin
                errors++;
                $display("FAIL ramp_settle actual=timeout required=idle");
            end
        end
        chk("ramp_start", pwm_duty_cycle, 8'h02);
        step(1, 16'h8405, 0);
        step(0, 16'h0000, 1);
        chk("ramp_commit", pwm_duty_cycle, 8'h02);
        chk("ramp_pend", {7'd0, duty_pending}, 8'h01);
        step(0, 16'h0000, 1); chk("ramp_03", pwm_duty_cycle, 8'h03);
        step(0, 16'h0000, 0); chk("ramp_hold", pwm_duty_cycle, 8'h03);
        step(0, 16'h0000, 1); chk("ramp_04", pwm_duty_cycle, 8'h04);
        step(0, 16'h0000, 1); chk("ramp_05", pwm_duty_cycle, 8'h05);
        chk("ramp_done", {7'd0, duty_pending}, 8'h00);
        // Write during ramp freezes active until the next commit
        step(1, 16'h8402, 0);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1); chk("down_04", pwm_duty_cycle, 8'h04);
        step(1, 16'h8409, 1); chk("freeze_04", pwm_duty_cycle, 8'h04);
        step(1, 16'h8401, 0);
        step(0, 16'h0000, 1); chk("recommit_04", pwm_duty_cycle, 8'h04);
        step(0, 16'h0000, 1); chk("down_03", pwm_duty_cycle, 8'h03);
        async_reset();
        step(0, 16'h0000, 1);
        chk("rst_discard", pwm_duty_cycle, DR);
`endif

        repeat (2) step(0, 16'h0000, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
